// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: ID/EX pipeline register with a 2-entry skid buffer; define IDEX_PERF_CNT_EN to add the perf_bubble_cnt/perf_flush_cnt outputs
module id_ex_skid_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_ctrl,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_ctrl
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);
  localparam int W = 4*XLEN + 17 + 3*REG_AW + 3;
  localparam logic [W-1:0] nop = {{XLEN{1'b0}}, 7'b0010011, 3'b000, 7'b0000000, {(3*XLEN+3*REG_AW+3){1'b0}}};
  logic [W-1:0] in_p, m_q, s_q, m_n, s_n;
  logic m_v, s_v, m_v_n, s_v_n, acc, ret;
  assign in_p = {id_pc, id_opcode, id_funct3, id_funct7, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl};
  assign {ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl} = m_q;
  assign ex_valid = m_v;
  always_comb begin
    acc   = id_valid & id_ready;
    ret   = m_v & ex_ready;
    m_v_n = flush ? 1'b0 : s_v | acc | (m_v & ~ret);
    s_v_n = flush ? 1'b0 : s_v ? ~ret : m_v & acc & ~ret;
    m_n   = flush ? nop : s_v ? (ret ? s_q : m_q) : (acc & (~m_v | ret)) ? in_p : ret ? nop : m_q;
    s_n   = (~s_v & m_v & acc & ~ret) ? in_p : s_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v      <= 1'b0;
      s_v      <= 1'b0;
      m_q      <= nop;
      s_q      <= nop;
      id_ready <= 1'b1;
    end else begin
      m_v      <= m_v_n;
      s_v      <= s_v_n;
      m_q      <= m_n;
      s_q      <= s_n;
      id_ready <= ~s_v_n;
    end
  end
`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (!m_v && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (flush && (m_v || s_v || acc) && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb_id_ex_skid_reg: queue-model checker plus directed vectors for id_ex_skid_reg
module tb_id_ex_skid_reg;
  localparam int W = 4*32 + 17 + 15 + 3;
  localparam logic [W-1:0] nop = {32'h0, 7'h13, 3'h0, 7'h0, 96'h0, 15'h0, 3'h0};
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic id_ready, ex_valid;
  logic [W-1:0] in_pl = '0, out_pl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0] id_opcode, id_funct7, ex_opcode, ex_funct7;
  logic [2:0] id_funct3, id_ctrl, ex_funct3, ex_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt, mb;
  logic [15:0] perf_flush_cnt, mf;
`endif
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] q[$];
  bit mrdy, a, r;
  always #5 clk = ~clk;
  assign {id_pc, id_opcode, id_funct3, id_funct7, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_ctrl} = in_pl;
  assign out_pl = {ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl};
  id_ex_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
`ifdef IDEX_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  function automatic logic [W-1:0] pl(input logic [31:0] pc);
    logic [4:0] f;
    f = pc[6:2];
    return {pc, 7'h33, pc[4:2], {pc[2], 6'h0}, pc ^ 32'hA5A5_0000, ~pc, pc + 32'd4, f, ~f, f + 5'd1, {1'b1, pc[3:2]}};
  endfunction
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mrdy = 1'b1;
`ifdef IDEX_PERF_CNT_EN
      mb = '0;
      mf = '0;
`endif
    end else begin
      a = id_valid && mrdy;
      r = q.size() > 0 && ex_ready;
`ifdef IDEX_PERF_CNT_EN
      if (q.size() == 0 && mb != '1) mb++;
      if (flush && (q.size() > 0 || a) && mf != '1) mf++;
`endif
      if (flush) q.delete();
      else begin
        if (r) void'(q.pop_front());
        if (a) q.push_back(in_pl);
      end
      mrdy = q.size() < 2;
    end
  end
  always @(negedge clk) begin
    check("model_ex_valid", 256'(ex_valid), 256'(q.size() > 0));
    check("model_id_ready", 256'(id_ready), 256'(mrdy));
    check("model_payload", 256'(out_pl), 256'(q.size() > 0 ? q[0] : nop));
`ifdef IDEX_PERF_CNT_EN
    check("model_bubble_cnt", 256'(perf_bubble_cnt), 256'(mb));
    check("model_flush_cnt", 256'(perf_flush_cnt), 256'(mf));
`endif
  end
  task automatic cyc(input logic v, input logic [31:0] pc, input logic er, input logic fl);
    id_valid = v;
    in_pl = pl(pc);
    ex_ready = er;
    flush = fl;
    @(negedge clk);
    #1;
  endtask
  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("reset_ex_valid", 256'(ex_valid), 256'(0));
    check("reset_id_ready", 256'(id_ready), 256'(1));
    check("reset_opcode", 256'(ex_opcode), 256'(7'h13));
    rst_n = 1'b1;
    repeat (5) cyc(0, 0, 1, 0);
`ifdef IDEX_PERF_CNT_EN
    check("idle_bubble_cnt", 256'(perf_bubble_cnt), 256'(5));
`endif
    cyc(1, 32'h100, 1, 0);
    check("first_valid", 256'(ex_valid), 256'(1));
    check("first_pc", 256'(ex_pc), 256'(32'h100));
    check("first_id_ready", 256'(id_ready), 256'(1));
    cyc(1, 32'h0, 1, 0);
    check("stream_pc0", 256'(ex_pc), 256'(32'h0));
    cyc(1, 32'h4, 1, 0);
    check("stream_pc4", 256'(ex_pc), 256'(32'h4));
    cyc(1, 32'h8, 1, 0);
    check("stream_pc8", 256'(ex_pc), 256'(32'h8));
    check("stream_valid", 256'(ex_valid), 256'(1));
    cyc(0, 0, 1, 0);
    check("drained", 256'(ex_valid), 256'(0));
    cyc(1, 32'h10, 0, 0);
    cyc(1, 32'h14, 0, 0);
    check("full_id_ready", 256'(id_ready), 256'(0));
    check("full_pc", 256'(ex_pc), 256'(32'h10));
    cyc(1, 32'h18, 0, 0);
    check("full_hold_pc", 256'(ex_pc), 256'(32'h10));
    cyc(0, 0, 1, 0);
    check("release_pc", 256'(ex_pc), 256'(32'h14));
    check("release_id_ready", 256'(id_ready), 256'(1));
    cyc(0, 0, 1, 0);
    check("release_empty", 256'(ex_valid), 256'(0));
    cyc(1, 32'h30, 0, 0);
    cyc(1, 32'h34, 0, 0);
    cyc(1, 32'h20, 0, 1);
    check("flush_valid", 256'(ex_valid), 256'(0));
    check("flush_ctrl", 256'(ex_ctrl), 256'(0));
    check("flush_opcode", 256'(ex_opcode), 256'(7'h13));
    check("flush_id_ready", 256'(id_ready), 256'(1));
`ifdef IDEX_PERF_CNT_EN
    check("flush_cnt_one", 256'(perf_flush_cnt), 256'(1));
`endif
    cyc(0, 0, 1, 1);
`ifdef IDEX_PERF_CNT_EN
    check("flush_cnt_empty", 256'(perf_flush_cnt), 256'(1));
`endif
    cyc(0, 0, 1, 0);
    check("no_0x20", 256'(ex_valid), 256'(0));
    cyc(1, 32'h50, 0, 0);
    cyc(1, 32'h54, 0, 0);
    check("pre_reset_full", 256'(id_ready), 256'(0));
    id_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_ex_valid", 256'(ex_valid), 256'(0));
    check("async_id_ready", 256'(id_ready), 256'(1));
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 32'h40, 1, 0);
    check("post_reset_pc", 256'(ex_pc), 256'(32'h40));
    check("post_reset_valid", 256'(ex_valid), 256'(1));
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- ID/EX pipeline boundary of the pipelined RV32I core, registered with a 2-entry skid buffer.
- Captures decoded fields, operands, immediate and control bits from ID, and presents them to EX.
- In EX, opcode/funct3/funct7 drive the ALU control decoder and the operands drive the ALU.
- Valid/ready on both sides; id_ready is a registered output, never combinational from ex_ready. Synchronous flush for taken branches/jumps.

Parameters:
XLEN, 32, operand/PC/immediate width
REG_AW, 5, register-index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID presents an instruction
id_ready  out  1  stage can accept (registered)
id_pc  in  XLEN  instruction PC
id_opcode  in  7  opcode field
id_funct3  in  3  funct3 field
id_funct7  in  7  funct7 field
id_rs1_data  in  XLEN  rs1 operand
id_rs2_data  in  XLEN  rs2 operand
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REG_AW  rs1 index
id_rs2  in  REG_AW  rs2 index
id_rd  in  REG_AW  rd index
id_ctrl  in  3  {reg_write, mem_read, mem_write}
flush  in  1  kill all held/incoming instructions
ex_ready  in  1  EX accepts the current entry
ex_valid  out  1  main entry valid
ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl  out  (widths as id_*)  main entry payload

Behaviour:
- Storage: main entry M drives ex_*; skid entry S. States EMPTY (none), BUSY (M valid), FULL (M and S valid).
- acc = id_valid & id_ready; ret = ex_valid & ex_ready.
- id_ready = 1 in EMPTY/BUSY, 0 in FULL; registered from next state.
- ex_valid = 1 in BUSY/FULL.
- EMPTY: acc -> BUSY, M<=in.
- BUSY, acc&ret -> BUSY, M<=in. acc&!ret -> FULL, S<=in. !acc&ret -> EMPTY. Neither -> hold.
- FULL: ret -> BUSY, M<=S. No acc possible.
- Latency: accept at edge N -> ex_valid with that payload after edge N. Throughput 1 instr/cycle while ex_ready=1.
- Order preserved: S always younger than M.
- Payload of an entry never changes while its valid is held and not retired.
- Bubble (ex_valid=0): ex_ctrl=3'b000, ex_opcode=7'b0010011, ex_funct3=0, ex_funct7=0, ex_rd=0. All other ex_* are 0, forming a canonical NOP.
- flush=1 at an edge: next state EMPTY, id_ready=1, ex_valid=0, bubble payload. Any same-cycle acc is discarded. Flush beats acc and ret.
- ex_ready is ignored while ex_valid=0. id_* is ignored while id_ready=0.
- Reset (async, rst_n=0): state EMPTY, id_ready=1, ex_valid=0, ex_* = bubble values. Applies immediately mid-operation; held entries are lost.
- No arithmetic on payload; widths pass through unchanged.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubble_cnt (32) and perf_flush_cnt (16).
  - perf_bubble_cnt increments each cycle ex_valid=0 and rst_n=1.
  - perf_flush_cnt increments on each flush edge that discards at least one valid entry (M, S or the incoming acc).
  - Both saturate at all-ones, reset to 0 asynchronously.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, id_valid=1 pc=0x100, ex_ready=1 -> ex_valid=1, ex_pc=0x100 one cycle after accept; id_ready stays 1.
- Stream pc 0x0,0x4,0x8 back-to-back, ex_ready=1 -> ex_pc 0x0,0x4,0x8 on consecutive cycles, no bubbles.
- ex_ready=0 while pc 0x10, 0x14 arrive -> FULL, id_ready=0, ex_pc=0x10. Release ex_ready -> 0x10 then 0x14 retire in order; id_ready returns 1 the cycle after leaving FULL.
- FULL plus flush=1 with id_valid=1 (pc 0x20) -> next cycle ex_valid=0, ex_ctrl=0, ex_opcode=0x13, id_ready=1; 0x20 never appears.
- rst_n low mid-stream while FULL -> ex_valid=0 and id_ready=1 immediately, without a clock edge. After release, first accept (pc 0x40) appears next cycle.
- With IDEX_PERF_CNT_EN: 5 idle cycles after reset -> perf_bubble_cnt=5. Flush with M valid -> perf_flush_cnt=1. Flush while EMPTY with id_valid=0 -> count unchanged.
